// File: rtl/decoder_status_aggregator.sv
// Reduces per-PU busy/odd flags through registered OR trees and holds the controller-facing
// status conservative until results from the current stage have fully flushed through the tree.
module decoder_status_aggregator #(
  parameter int CODE_DISTANCE_X = 3,
  parameter int CODE_DISTANCE_Z = 2,
  parameter int STAGE_WIDTH     = 3,
  parameter int TREE_FANIN      = 4,
  parameter int QUIET_CYCLES    = 2,
  localparam int MEASUREMENT_ROUNDS =
    (CODE_DISTANCE_X > CODE_DISTANCE_Z) ? CODE_DISTANCE_X : CODE_DISTANCE_Z,
  localparam int PU_COUNT = CODE_DISTANCE_X * CODE_DISTANCE_Z * MEASUREMENT_ROUNDS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [STAGE_WIDTH-1:0] stage,
  input  logic [PU_COUNT-1:0]    pu_busy,
  input  logic [PU_COUNT-1:0]    pu_odd,
  output logic                   has_message_flying,
  output logic                   has_odd_clusters,
  output logic                   status_valid
);

  localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE = '0;

  function automatic int level_width(int lvl);
    int w;
    w = PU_COUNT;
    for (int i = 0; i < lvl; i++) w = (w + TREE_FANIN - 1) / TREE_FANIN;
    return w;
  endfunction

  function automatic int level_count();
    int w;
    int n;
    w = PU_COUNT;
    n = 0;
    while (w > 1) begin
      w = (w + TREE_FANIN - 1) / TREE_FANIN;
      n++;
    end
    return (n < 1) ? 1 : n;
  endfunction

  // Bit offset of a tree level inside the flattened register vector (level 1 starts at 0).
  function automatic int level_offset(int lvl);
    int off;
    off = 0;
    for (int i = 1; i < lvl; i++) off += level_width(i);
    return off;
  endfunction

  localparam int L         = level_count();
  localparam int GUARD     = L + 1;
  localparam int TREE_BITS = level_offset(L + 1);
  localparam int GUARD_W   = $clog2(GUARD + 1);

  localparam logic [GUARD_W-1:0] GUARD_INIT = GUARD_W'(GUARD);
  localparam logic [3:0]         QUIET_MAX  = 4'(QUIET_CYCLES);

  logic [TREE_BITS-1:0]   busy_tree;
  logic [TREE_BITS-1:0]   odd_tree;
  logic [TREE_BITS-1:0]   busy_next;
  logic [TREE_BITS-1:0]   odd_next;
  logic                   tree_busy;
  logic                   tree_odd;
  logic [STAGE_WIDTH-1:0] stage_q;
  logic [GUARD_W-1:0]     guard_cnt;
  logic [3:0]             quiet_cnt;
  logic                   odd_q;

  // The last node of each level may see fewer than TREE_FANIN inputs; missing leaves act as 0.
  for (genvar lv = 1; lv <= L; lv++) begin : g_level
    localparam int IN_W     = level_width(lv - 1);
    localparam int OUT_W    = level_width(lv);
    localparam int OFF      = level_offset(lv);
    localparam int PREV_OFF = level_offset(lv - 1);
    for (genvar n = 0; n < OUT_W; n++) begin : g_node
      localparam int LO  = n * TREE_FANIN;
      localparam int CNT = (IN_W - LO < TREE_FANIN) ? (IN_W - LO) : TREE_FANIN;
      if (lv == 1) begin : g_leaf
        assign busy_next[OFF + n] = |pu_busy[LO +: CNT];
        assign odd_next[OFF + n]  = |pu_odd[LO +: CNT];
      end else begin : g_inner
        assign busy_next[OFF + n] = |busy_tree[PREV_OFF + LO +: CNT];
        assign odd_next[OFF + n]  = |odd_tree[PREV_OFF + LO +: CNT];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_tree <= '0;
      odd_tree  <= '0;
    end else begin
      busy_tree <= busy_next;
      odd_tree  <= odd_next;
    end
  end

  assign tree_busy = busy_tree[TREE_BITS-1];
  assign tree_odd  = odd_tree[TREE_BITS-1];

  // Any stage change restarts the guard so stale tree contents never reach the outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q   <= STAGE_IDLE;
      guard_cnt <= GUARD_INIT;
      quiet_cnt <= '0;
      odd_q     <= 1'b0;
    end else if (stage != stage_q) begin
      stage_q   <= stage;
      guard_cnt <= GUARD_INIT;
      quiet_cnt <= '0;
    end else if (guard_cnt != '0) begin
      guard_cnt <= guard_cnt - GUARD_W'(1);
      quiet_cnt <= '0;
    end else begin
      if (tree_busy) quiet_cnt <= '0;
      else if (quiet_cnt < QUIET_MAX) quiet_cnt <= quiet_cnt + 4'd1;
      odd_q <= tree_odd;
    end
  end

  assign has_message_flying = (guard_cnt != '0) || (quiet_cnt < QUIET_MAX);
  assign status_valid       = (guard_cnt == '0);
  assign has_odd_clusters   = odd_q;

endmodule

// File: tb/tb_decoder_status_aggregator.sv
// Scoreboard bench for decoder_status_aggregator: the driver queues hand-computed
// {flying, valid, odd} for every stepped edge, a negedge monitor pops and compares.
module tb_decoder_status_aggregator;

  localparam logic [2:0] STAGE_IDLE    = 3'd0;
  localparam logic [2:0] STAGE_PREP    = 3'd1;
  localparam logic [2:0] STAGE_LOADING = 3'd2;
  localparam logic [2:0] STAGE_SPREAD  = 3'd3;
  localparam logic [2:0] STAGE_SYNC    = 3'd4;
  localparam logic [2:0] STAGE_RESULT  = 3'd5;

  typedef struct {
    logic [2:0] expv;
    string      name;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  stage;
  logic [17:0] pu_busy;
  logic [17:0] pu_odd;
  logic        has_message_flying;
  logic        has_odd_clusters;
  logic        status_valid;

  exp_t sb[$];
  int   check_cnt = 0;
  int   pass_cnt  = 0;

  decoder_status_aggregator dut (
    .clk                (clk),
    .reset              (reset),
    .stage              (stage),
    .pu_busy            (pu_busy),
    .pu_odd             (pu_odd),
    .has_message_flying (has_message_flying),
    .has_odd_clusters   (has_odd_clusters),
    .status_valid       (status_valid)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input exp_t e);
    logic [2:0] actual;
    actual = {has_message_flying, status_valid, has_odd_clusters};
    check_cnt++;
    if (actual === e.expv) pass_cnt++;
    else $display("[TB] FAIL %s: fly/valid/odd got %b required %b", e.name, actual, e.expv);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) checkOutput(sb.pop_front());
  end

  // Drives one cycle of inputs, steps one edge, and queues the outputs expected after it.
  task automatic applyStimulus(input logic rst, input logic [2:0] st, input logic [17:0] b,
                               input logic [17:0] o, input logic [2:0] expv, input string nm);
    exp_t e;
    reset   = rst;
    stage   = st;
    pu_busy = b;
    pu_odd  = o;
    @(posedge clk);
    #1;
    e.expv = expv;
    e.name = nm;
    sb.push_back(e);
  endtask

  // After a stage change: guard keeps valid low for 4 edges, flying drops at edge 6,
  // odd_q first samples the tree on edge 5.
  task automatic stageChange(input logic [2:0] st, input logic [17:0] o,
                             input logic odd_before, input logic odd_after, input string nm);
    for (int i = 0; i <= 6; i++)
      applyStimulus(1'b0, st, 18'd0, o,
                    {i < 6, i >= 4, (i >= 5) ? odd_after : odd_before},
                    $sformatf("%s_e%0d", nm, i));
  endtask

  task automatic releaseSeq(input string nm);
    for (int i = 1; i <= 7; i++)
      applyStimulus(1'b0, STAGE_IDLE, 18'd0, 18'd0, {i < 6, i >= 4, 1'b0},
                    $sformatf("%s_e%0d", nm, i));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset   = 1'b1;
    stage   = STAGE_IDLE;
    pu_busy = '0;
    pu_odd  = '0;

    applyStimulus(1'b1, STAGE_IDLE, 18'd0, 18'd0, 3'b100, "reset_a");
    applyStimulus(1'b1, STAGE_IDLE, 18'd0, 18'd0, 3'b100, "reset_b");
    releaseSeq("release");

    // Single busy pulse on the highest PU index.
    for (int i = 0; i <= 5; i++)
      applyStimulus(1'b0, STAGE_IDLE, (i == 0) ? 18'h20000 : 18'd0, 18'd0,
                    {(i == 3) || (i == 4), 1'b1, 1'b0}, $sformatf("pulse17_e%0d", i));

    stageChange(STAGE_SPREAD, 18'h00020, 1'b0, 1'b1, "spread");
    stageChange(STAGE_SYNC,   18'h00020, 1'b1, 1'b1, "sync");
    stageChange(STAGE_IDLE,   18'd0,     1'b1, 1'b0, "to_idle");

    // Second change two edges after the first must restart the guard.
    applyStimulus(1'b0, STAGE_LOADING, 18'd0, 18'd0, 3'b100, "loading_e0");
    applyStimulus(1'b0, STAGE_LOADING, 18'd0, 18'd0, 3'b100, "loading_e1");
    stageChange(STAGE_RESULT, 18'd0, 1'b0, 1'b0, "restart");

    // Busy toggling every cycle keeps quiet_cnt from ever reaching the threshold.
    for (int i = 0; i <= 19; i++)
      applyStimulus(1'b0, STAGE_RESULT, (i <= 11 && i % 2 == 0) ? 18'h00001 : 18'd0,
                    18'h00200, {i >= 3 && i <= 14, 1'b1, i >= 3},
                    $sformatf("toggle_e%0d", i));

    for (int i = 0; i <= 2; i++)
      applyStimulus(1'b0, STAGE_PREP, 18'd0, 18'h00200, 3'b101, $sformatf("prep_e%0d", i));
    applyStimulus(1'b1, STAGE_PREP, 18'd0, 18'h00200, 3'b100, "midreset");
    releaseSeq("rerelease");

    @(negedge clk);
    @(negedge clk);
    if (sb.size() != 0) begin
      $display("[TB] FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
      check_cnt += sb.size();
    end
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
